// File: rtl/riscv_mac_ops_ctrl.sv
// MAC-class custom instruction unit: packed int8 dot products,
// max-pool, ReLU and accumulator access, sequenced one lane per cycle.
module riscv_mac_ops_ctrl #(
  parameter logic [31:0] ACC_RST_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [2:0]  operator_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] operand_c_i,
  input  logic        ex_ready_i,
  input  logic        clear_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        illegal_o,
  output logic [31:0] acc_o
);

  localparam logic [2:0] MAC_OP      = 3'd0;
  localparam logic [2:0] CON_2X2_OP  = 3'd1;
  localparam logic [2:0] CON_OP      = 3'd2;
  localparam logic [2:0] WB23_OP     = 3'd3;
  localparam logic [2:0] MAX_POOL_OP = 3'd4;
  localparam logic [2:0] RELU_OP     = 3'd5;
  localparam logic [2:0] W_WB_OP     = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, nstate;
  logic [1:0]  lc;
  logic [31:0] p, acc;
  logic [31:0] a_q, b_q;
  logic [2:0]  op_q;

  logic        is_multi;
  logic        start;
  logic        acc_we;
  logic [31:0] acc_d;
  logic [31:0] relu;
  logic [31:0] p_init;

  logic signed [7:0]  la, lb;
  logic signed [15:0] prod;
  logic [31:0]        prod_x, lane_x;

  assign is_multi = (operator_i == MAC_OP)
                 || (operator_i == CON_2X2_OP)
                 || (operator_i == CON_OP)
                 || (operator_i == MAX_POOL_OP);

  assign acc_o  = acc;
  assign busy_o = (state == BUSY) || (state == DONE);

  // Current lane product and sign-extended lane of latched a
  always_comb begin
    la     = a_q[{lc, 3'b000} +: 8];
    lb     = b_q[{lc, 3'b000} +: 8];
    prod   = la * lb;
    prod_x = {{16{prod[15]}}, prod};
    lane_x = {{24{la[7]}}, la};
  end

  // ReLU on each byte of the live operand a
  always_comb begin
    relu = 32'h0;
    for (int k = 0; k < 4; k++) begin
      relu[8*k +: 8] = operand_a_i[8*k+7] ? 8'h00
                                          : operand_a_i[8*k +: 8];
    end
  end

  // Starting partial value for a new multi-cycle op
  always_comb begin
    p_init = 32'h0;
    if (operator_i == MAC_OP) begin
      p_init = operand_c_i;
    end else if (operator_i == MAX_POOL_OP) begin
      p_init = {{24{operand_a_i[7]}}, operand_a_i[7:0]};
    end
  end

  // Next state, handshake outputs and accumulator write control
  always_comb begin
    nstate    = state;
    ready_o   = 1'b0;
    result_o  = 32'h0;
    illegal_o = 1'b0;
    acc_we    = 1'b0;
    acc_d     = acc;
    start     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (enable_i) begin
          if (is_multi) begin
            start  = 1'b1;
            nstate = BUSY;
          end else begin
            ready_o = 1'b1;
            case (operator_i)
              WB23_OP: result_o = acc;
              RELU_OP: result_o = relu;
              W_WB_OP: begin
                result_o = operand_a_i;
                acc_we   = ex_ready_i;
                acc_d    = operand_a_i;
              end
              default: illegal_o = 1'b1;
            endcase
          end
        end
      end
      (state == BUSY): begin
        if (lc == 2'd3) begin
          nstate = DONE;
        end
      end
      (state == DONE): begin
        ready_o  = 1'b1;
        result_o = (op_q == CON_OP) ? acc + p : p;
        if (ex_ready_i) begin
          nstate = IDLE;
          if (op_q == CON_OP) begin
            acc_we = 1'b1;
            acc_d  = acc + p;
          end
        end
      end
      default: nstate = IDLE;
    endcase
    if (clear_i) begin
      nstate  = IDLE;
      acc_we  = 1'b0;
      ready_o = 1'b0;
      start   = 1'b0;
    end
  end

  // State, lane counter, partial, operand latches and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lc    <= 2'd0;
      p     <= 32'h0;
      acc   <= ACC_RST_VAL;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      op_q  <= MAC_OP;
    end else begin
      state <= nstate;
      if (acc_we) begin
        acc <= acc_d;
      end
      if (clear_i) begin
        lc <= 2'd0;
      end else if (start) begin
        a_q  <= operand_a_i;
        b_q  <= operand_b_i;
        op_q <= operator_i;
        p    <= p_init;
        lc   <= 2'd0;
      end else if (state == BUSY) begin
        if (op_q == MAX_POOL_OP) begin
          if ($signed(lane_x) > $signed(p)) begin
            p <= lane_x;
          end
        end else begin
          p <= p + prod_x;
        end
        lc <= lc + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mac_ops_ctrl.sv
// Directed bench for riscv_mac_ops_ctrl with an expected-result
// queue popped whenever the unit presents a result.
module tb_riscv_mac_ops_ctrl;

  localparam logic [2:0] MAC_OP      = 3'd0;
  localparam logic [2:0] CON_2X2_OP  = 3'd1;
  localparam logic [2:0] CON_OP      = 3'd2;
  localparam logic [2:0] WB23_OP     = 3'd3;
  localparam logic [2:0] MAX_POOL_OP = 3'd4;
  localparam logic [2:0] RELU_OP     = 3'd5;
  localparam logic [2:0] W_WB_OP     = 3'd6;
  localparam logic [2:0] BAD_OP      = 3'd7;
  localparam logic [31:0] RST_ACC    = 32'h5A5A0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  operator;
  logic [31:0] op_a, op_b, op_c;
  logic        ex_ready;
  logic        clear;
  logic [31:0] result;
  logic        ready, busy, illegal;
  logic [31:0] acc;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] acc_m;

  riscv_mac_ops_ctrl #(.ACC_RST_VAL(RST_ACC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .operator_i (operator),
    .operand_a_i(op_a),
    .operand_b_i(op_b),
    .operand_c_i(op_c),
    .ex_ready_i (ex_ready),
    .clear_i    (clear),
    .result_o   (result),
    .ready_o    (ready),
    .busy_o     (busy),
    .illegal_o  (illegal),
    .acc_o      (acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_multi(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] exp_res,
                          input logic [31:0] exp_acc, input int stall);
    int cyc;
    logic [31:0] e;
    sb.push_back(exp_res);
    @(posedge clk); #1;
    enable = 1'b1; operator = op;
    op_a = a; op_b = b; op_c = c;
    ex_ready = (stall == 0);
    @(negedge clk);
    chk("rdy_c0", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    enable = 1'b0;
    op_a = $urandom; op_b = $urandom; op_c = $urandom;
    cyc = 1;
    @(negedge clk);
    while (ready !== 1'b1 && cyc < 8) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 32'd5);
    chk("busy_done", {31'b0, busy}, 32'd1);
    e = sb.pop_front();
    chk("result", result, e);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_res", result, e);
      chk("stall_acc", acc, acc_m);
    end
    ex_ready = 1'b1;
    @(posedge clk); #1;
    acc_m = exp_acc;
    chk("acc_after", acc, acc_m);
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_single(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] exp_res,
                           input logic exp_ill,
                           input logic [31:0] exp_acc);
    logic [31:0] e;
    sb.push_back(exp_res);
    @(posedge clk); #1;
    enable = 1'b1; operator = op; op_a = a; ex_ready = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    chk("s_ready", {31'b0, ready}, 32'd1);
    chk("s_result", result, e);
    chk("s_illegal", {31'b0, illegal}, {31'b0, exp_ill});
    @(posedge clk); #1;
    enable = 1'b0;
    acc_m = exp_acc;
    chk("s_acc", acc, acc_m);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; operator = MAC_OP;
    op_a = '0; op_b = '0; op_c = '0;
    ex_ready = 1'b1; clear = 1'b0;
    acc_m = RST_ACC;
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_acc", acc, RST_ACC);
    @(negedge clk); rst_n = 1'b1;

    do_single(WB23_OP, 32'h0, RST_ACC, 1'b0, RST_ACC);
    do_multi(MAC_OP, 32'h01020304, 32'h01010101, 32'd10,
             32'h14, acc_m, 0);
    do_multi(CON_2X2_OP, 32'hFF020304, 32'h02020202, 32'd0,
             32'h10, acc_m, 0);
    do_multi(MAX_POOL_OP, 32'h80FFFEFD, 32'h0, 32'h0,
             32'hFFFFFFFF, acc_m, 0);
    do_single(W_WB_OP, 32'h100, 32'h100, 1'b0, 32'h100);
    do_multi(CON_OP, 32'h01010101, 32'h02020202, 32'h0,
             32'h108, 32'h108, 0);
    do_single(WB23_OP, 32'h0, 32'h108, 1'b0, 32'h108);
    do_single(RELU_OP, 32'h80FF7F05, 32'h00007F05, 1'b0, 32'h108);
    do_single(BAD_OP, 32'h12345678, 32'h0, 1'b1, 32'h108);

    // W_WB held without acceptance must not write ACC
    @(posedge clk); #1;
    enable = 1'b1; operator = W_WB_OP; op_a = 32'hDEAD; ex_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("wwb_hold_res", result, 32'hDEAD);
    chk("wwb_hold_acc", acc, acc_m);
    enable = 1'b0; ex_ready = 1'b1;

    // CON_OP stalled three cycles in DONE
    do_multi(CON_OP, 32'h01010101, 32'h02020202, 32'h0,
             32'h110, 32'h110, 3);

    // Flush in BUSY cycle 2
    @(posedge clk); #1;
    enable = 1'b1; operator = CON_OP;
    op_a = 32'h01010101; op_b = 32'h02020202;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(negedge clk);
    chk("clr_ready", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("clr_noready", {31'b0, ready}, 32'd0);
    end
    chk("clr_acc", acc, acc_m);

    // Asynchronous reset mid-BUSY
    @(posedge clk); #1;
    enable = 1'b1; operator = MAC_OP;
    op_a = 32'h01020304; op_b = 32'h01010101; op_c = 32'd10;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ready", {31'b0, ready}, 32'd0);
    chk("arst_illegal", {31'b0, illegal}, 32'd0);
    chk("arst_acc", acc, RST_ACC);
    chk("arst_result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    acc_m = RST_ACC;
    do_multi(MAC_OP, 32'h01020304, 32'h01010101, 32'd10,
             32'h14, acc_m, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mac_ops_ctrl.md
RISCV_MAC_OPS_CTRL -- requirements
Module: riscv_mac_ops_ctrl

Interface
REQ-001 Parameter: ACC_RST_VAL, default 32'h0, value loaded into the accumulator at reset.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 enable_i  input  1  custom MAC-class instruction present in EX (OPCODE_MAC_OPS).
REQ-005 operator_i  input  MAC_OP_WIDTH (3)  MAC_OP / CON_2X2_OP / CON_OP / WB23_OP / MAX_POOL_OP / RELU_OP / W_WB_OP encoding.
REQ-006 operand_a_i, operand_b_i, operand_c_i  input  32 each  packed 4x signed int8 (a, b); 32-bit addend (c).
REQ-007 ex_ready_i  input  1  downstream accepts the result this cycle.
REQ-008 clear_i  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 result_o  output  32  result; valid only while ready_o=1.
REQ-010 ready_o  output  1  result_o valid for the current instruction.
REQ-011 busy_o  output  1  multi-cycle operation in progress (state BUSY or DONE).
REQ-012 illegal_o  output  1  operator_i=3'b111 presented with enable_i.
REQ-013 acc_o  output  32  current accumulator contents.

Function
REQ-014 States: IDLE, BUSY, DONE; 2-bit lane counter LC; 32-bit partial register P; 32-bit accumulator ACC.
REQ-015 Byte lane k = operand bits [8k+7:8k], k=0..3, signed; each product is a 16-bit signed value sign-extended to 32 bits; all sums wrap modulo 2^32.
REQ-016 Multi-cycle ops are MAC_OP, CON_2X2_OP, CON_OP, MAX_POOL_OP; single-cycle ops are WB23_OP, RELU_OP, W_WB_OP, and illegal.
REQ-017 IDLE with enable_i and a multi-cycle op: latch a and b; P initialised to operand_c_i (MAC_OP), to the sign-extended lane 0 of a (MAX_POOL_OP), or to 0 (CON_2X2_OP, CON_OP); LC=0; go to BUSY.
REQ-018 BUSY: one lane per cycle, LC 0->3. MAC/CON ops: P += a[LC]*b[LC]. MAX_POOL: P = signed max(P, a[LC]). After LC=3, go to DONE.
REQ-019 DONE: ready_o=1. result_o = P, except CON_OP, where result_o = ACC + P.
REQ-020 DONE with ex_ready_i=1: go to IDLE; for CON_OP, ACC <= ACC + P in the same edge. DONE with ex_ready_i=0: hold state, P and result_o.
REQ-021 Multi-cycle latency: enable_i sampled in cycle 0 gives ready_o=1 in cycle 5; ready_o=0 in cycles 0-4.
REQ-022 IDLE with enable_i and a single-cycle op: ready_o=1 combinationally in the same cycle.
  - WB23_OP: result_o = ACC.
  - RELU_OP: each byte of a with bit7 set is replaced by 8'h00; other bytes pass unchanged.
  - W_WB_OP: result_o = operand_a_i; ACC <= operand_a_i on an edge where ex_ready_i=1.
  - Illegal: result_o = 0; illegal_o=1.
REQ-023 Single-cycle op with ex_ready_i=0: stay IDLE, keep outputs combinational on the held inputs, no ACC write.
REQ-024 enable_i is ignored in BUSY and DONE; operands are taken only from the latched copies.
REQ-025 clear_i=1 in any state: next state IDLE, LC=0, no ACC write that cycle (overrides REQ-020 and REQ-022); ready_o is forced to 0 while clear_i=1.
REQ-026 busy_o=1 in BUSY and DONE only; illegal_o=0 outside IDLE.

Reset
REQ-027 rst_n low, asynchronously: state IDLE, LC=0, P=0, ACC=ACC_RST_VAL.
REQ-028 Output values during reset: ready_o=0, busy_o=0, illegal_o=0, result_o=0 (enable_i low), acc_o=ACC_RST_VAL.
REQ-029 Reset asserted mid-BUSY or mid-DONE discards the operation; no ACC update.

Verification
REQ-030 MAC_OP, a=0x01020304, b=0x01010101, c=10 -> ready_o rises in cycle 5, result_o=0x00000014, busy_o=1 in cycles 1-5.
REQ-031 CON_2X2_OP, a=0xFF020304, b=0x02020202 -> result_o=0x00000010. Then MAX_POOL_OP, a=0x80FFFEFD -> result_o=0xFFFFFFFF.
REQ-032 Accumulator sequence:
  - W_WB_OP a=0x00000100 -> acc_o=0x100.
  - CON_OP a=0x01010101, b=0x02020202 -> result_o=0x108, acc_o=0x108 after accept.
  - WB23_OP -> result_o=0x108 in the same cycle.
REQ-033 RELU_OP a=0x80FF7F05 -> result_o=0x00007F05 same cycle. Opcode 3'b111 -> illegal_o=1, result_o=0.
REQ-034 Stall and flush:
  - CON_OP held in DONE with ex_ready_i=0 for 3 cycles -> result_o stable; ACC changes only on the accept edge.
  - clear_i in BUSY cycle 2 -> IDLE next cycle, ACC unchanged, ready_o never asserted.
REQ-035 rst_n pulsed low mid-BUSY -> immediate IDLE, ACC=ACC_RST_VAL, all flags 0.
